// File: rtl/uart_txq.sv
// Transmit queue between the CPU bus and the uart: buffers TX bytes and feeds them to the uart.
// Optional CR insertion before LF is enabled by defining UART_TXQ_CRLF_EN.
module uart_txq #(
    parameter int         DEPTH_LOG2    = 4,
    parameter logic [3:0] UART_DATA_ADR = 4'h0,
    parameter logic [3:0] UART_STAT_ADR = 4'h8
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [3:0]  s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    output logic        s_ack_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, POLL, RDWAIT, WRITE, GAP} state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow, full, empty;
    logic                  push_req, push, pop, cr_next, crlf_flag;
    logic [1:0]            reg_sel;
    logic [7:0]            head;
    logic [31:0]           status;
    logic                  unused;

    assign unused   = &{1'b0, m_ack_i, s_sel_i, s_adr_i[1:0], s_dat_i[31:8], m_dat_i[31:1]};
    assign s_ack_o  = s_stb_i;
    assign m_sel_o  = 4'hF;
    assign reg_sel  = s_adr_i[3:2];
    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign head     = mem[rd_ptr];
    assign push_req = s_stb_i && s_we_i && (reg_sel == 2'd0);
    assign push     = push_req && !full;
    assign pop      = (state == WRITE) && !cr_next;

`ifdef UART_TXQ_CRLF_EN
    logic crlf_sent;
    assign crlf_flag = 1'b1;
    assign cr_next   = (head == 8'h0A) && !crlf_sent;

    // A CR pass leaves the LF at the head; the following pass sends and pops it.
    always_ff @(posedge clk) begin
        if (rst_i)
            crlf_sent <= 1'b0;
        else if (state == WRITE)
            crlf_sent <= cr_next;
    end
`else
    assign crlf_flag = 1'b0;
    assign cr_next   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_dat_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            else if (s_stb_i && s_we_i && (reg_sel == 2'd1) && s_dat_i[2])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = overflow;
        status[3]     = (state != IDLE);
        status[4]     = crlf_flag;
        status[15:8]  = 8'(level);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            s_dat_o <= '0;
        end else if (s_stb_i && !s_we_i) begin
            case (reg_sel)
                2'd1:    s_dat_o <= status;
                2'd2:    s_dat_o <= 32'(DEPTH);
                default: s_dat_o <= '0;
            endcase
        end
    end

    // Outputs are registered on entry to each state, so a strobe lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= IDLE;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= POLL;
                        m_stb_o <= 1'b1;
                        m_we_o  <= 1'b0;
                        m_adr_o <= UART_STAT_ADR;
                    end
                end
                POLL: begin
                    state   <= RDWAIT;
                    m_stb_o <= 1'b0;
                end
                RDWAIT: begin
                    m_stb_o <= 1'b1;
                    if (m_dat_i[0]) begin
                        state   <= POLL;
                        m_we_o  <= 1'b0;
                        m_adr_o <= UART_STAT_ADR;
                    end else begin
                        state   <= WRITE;
                        m_we_o  <= 1'b1;
                        m_adr_o <= UART_DATA_ADR;
                        m_dat_o <= {24'h0, cr_next ? 8'h0D : head};
                    end
                end
                WRITE: begin
                    state   <= GAP;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    m_stb_o <= 1'b0;
                    m_we_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_txq.sv
// Directed self-checking bench for uart_txq with a small busy-bit uart model.
// Honours UART_TXQ_CRLF_EN the same way as the design.
module tb_uart_txq;
`ifdef UART_TXQ_CRLF_EN
    localparam logic [31:0] CRLF_BIT = 32'h10;
`else
    localparam logic [31:0] CRLF_BIT = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [3:0]  s_sel_i = 4'hF;
    logic        s_we_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_ack_o;
    logic [31:0] s_dat_o;
    logic [3:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    int errors = 0;
    int checks = 0;

    // uart model state
    logic        force_busy = 1'b0;
    int          busy_hold = 0;
    int          busy_cnt = 0;
    logic        busy;
    logic        prev_stb = 1'b0;
    int          cyc = 0;
    int          polls = 0;
    int          stbs = 0;
    int          consec = 0;
    int          wbusy = 0;
    int          badadr = 0;
    int          last_poll_cyc = 0;
    int          last_write_cyc = 0;
    logic [3:0]  last_poll_adr = '0;
    logic [31:0] wlog[$];

    assign busy    = force_busy || (busy_cnt != 0);
    assign m_dat_i = {31'b0, busy};
    assign m_ack_i = m_stb_o;

    uart_txq dut (
        .clk(clk), .rst_i(rst_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
        .s_we_i(s_we_i), .s_stb_i(s_stb_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
        .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_stb_o) begin
            stbs = stbs + 1;
            if (prev_stb) consec = consec + 1;
            if (m_we_o) begin
                wlog.push_back(m_dat_o);
                if (busy) wbusy = wbusy + 1;
                if (m_adr_o != 4'h0) badadr = badadr + 1;
                last_write_cyc = cyc;
                busy_cnt = busy_hold;
            end else begin
                polls = polls + 1;
                last_poll_cyc = cyc;
                last_poll_adr = m_adr_o;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        prev_stb = m_stb_o;
    end

    task automatic bus_write(input logic [3:0] adr, input logic [31:0] dat);
        @(negedge clk);
        s_adr_i = adr; s_dat_i = dat; s_we_i = 1'b1; s_stb_i = 1'b1;
        @(negedge clk);
        s_we_i = 1'b0; s_stb_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] adr, output logic [31:0] dat);
        @(negedge clk);
        s_adr_i = adr; s_we_i = 1'b0; s_stb_i = 1'b1;
        @(negedge clk);
        s_stb_i = 1'b0;
        dat = s_dat_o;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int s0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b we=%b adr=%h mdat=%h sdat=%h required all 0",
                     m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o);
        end
        rst_i = 1'b0;
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h2 | CRLF_BIT)) begin
            errors++; $display("FAIL reset_status: got %h required %h", rd, 32'h2 | CRLF_BIT);
        end
        bus_read(4'h8, rd);
        checks++;
        if (rd !== 32'd16) begin
            errors++; $display("FAIL depth_reg: got %h required %h", rd, 32'd16);
        end
        s0 = stbs;
        repeat (20) @(negedge clk);
        checks++;
        if (stbs !== s0) begin
            errors++; $display("FAIL idle_no_strobe: got %0d strobes required 0", stbs - s0);
        end
    endtask

    task automatic test_single;
        logic [31:0] rd;
        wlog.delete();
        busy_hold = 0;
        bus_write(4'h0, 32'hFFFF_FF41);
        for (int i = 0; i < 50 && wlog.size() < 1; i++) @(negedge clk);
        checks++;
        if (wlog.size() !== 1 || wlog[0] !== 32'h41) begin
            errors++;
            $display("FAIL single_write: got %0d writes first=%h required 1 write of %h",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 32'hx, 32'h41);
        end
        checks++;
        if (last_poll_adr !== 4'h8) begin
            errors++; $display("FAIL poll_addr: got %h required %h", last_poll_adr, 4'h8);
        end
        checks++;
        if (last_write_cyc - last_poll_cyc !== 2) begin
            errors++;
            $display("FAIL poll_to_write: got %0d cycles required 2", last_write_cyc - last_poll_cyc);
        end
        repeat (3) @(negedge clk);
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h2 | CRLF_BIT)) begin
            errors++; $display("FAIL single_status: got %h required %h", rd, 32'h2 | CRLF_BIT);
        end
    endtask

    task automatic test_busy_uart;
        logic [31:0] exp [3];
        int p0;
        exp[0] = 32'h61; exp[1] = 32'h62; exp[2] = 32'h63;
        wlog.delete();
        wbusy = 0;
        p0 = polls;
        busy_hold = 30;
        for (int i = 0; i < 3; i++) bus_write(4'h0, exp[i]);
        for (int i = 0; i < 400 && wlog.size() < 3; i++) @(negedge clk);
        checks++;
        if (wlog.size() !== 3 || wlog[0] !== exp[0] || wlog[1] !== exp[1] || wlog[2] !== exp[2]) begin
            errors++;
            $display("FAIL busy_order: got %0d writes required 61,62,63 in order", wlog.size());
        end
        checks++;
        if (wbusy !== 0) begin
            errors++; $display("FAIL write_while_busy: got %0d required 0", wbusy);
        end
        checks++;
        if (polls - p0 <= 3) begin
            errors++; $display("FAIL repeated_polls: got %0d polls required more than 3", polls - p0);
        end
        busy_hold = 0;
        for (int i = 0; i < 40 && busy_cnt != 0; i++) @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [31:0] rd;
        int n;
        wlog.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) bus_write(4'h0, 32'h30 + 32'(i));
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h100D | CRLF_BIT)) begin
            errors++; $display("FAIL full_status: got %h required %h", rd, 32'h100D | CRLF_BIT);
        end
        bus_write(4'h4, 32'h4);
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h1009 | CRLF_BIT)) begin
            errors++; $display("FAIL ovf_clear: got %h required %h", rd, 32'h1009 | CRLF_BIT);
        end
        force_busy = 1'b0;
        for (int i = 0; i < 400 && wlog.size() < 16; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n = wlog.size();
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL drain_count: got %0d writes required 16", n);
        end
        for (int i = 0; i < 16 && i < n; i++) begin
            checks++;
            if (wlog[i] !== 32'h30 + 32'(i)) begin
                errors++; $display("FAIL drain_byte[%0d]: got %h required %h", i, wlog[i], 32'h30 + 32'(i));
            end
        end
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h2 | CRLF_BIT)) begin
            errors++; $display("FAIL drained_status: got %h required %h", rd, 32'h2 | CRLF_BIT);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] rd;
        logic seen;
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h50 + 32'(i));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (m_stb_o && !m_we_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL find_poll: got no poll strobe required one within 50 cycles");
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (m_stb_o !== 1'b0) begin
            errors++; $display("FAIL rst_stb: got %b required 0", m_stb_o);
        end
        wlog.delete();
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (wlog.size() !== 0) begin
            errors++; $display("FAIL rst_no_writes: got %0d writes required 0", wlog.size());
        end
        bus_read(4'h4, rd);
        checks++;
        if (rd !== (32'h2 | CRLF_BIT)) begin
            errors++; $display("FAIL rst_status: got %h required %h", rd, 32'h2 | CRLF_BIT);
        end
    endtask

    task automatic test_crlf;
        logic [31:0] rd;
        logic [31:0] exp[$];
`ifdef UART_TXQ_CRLF_EN
        exp = '{32'h48, 32'h0D, 32'h0A};
`else
        exp = '{32'h48, 32'h0A};
`endif
        wlog.delete();
        bus_write(4'h0, 32'h48);
        bus_write(4'h0, 32'h0A);
        for (int i = 0; i < 100 && wlog.size() < exp.size(); i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (wlog.size() !== exp.size()) begin
            errors++; $display("FAIL crlf_count: got %0d writes required %0d", wlog.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp[i]) begin
                errors++; $display("FAIL crlf_byte[%0d]: got %h required %h", i, wlog[i], exp[i]);
            end
        end
        bus_read(4'h4, rd);
        checks++;
        if (rd[4] !== CRLF_BIT[4]) begin
            errors++; $display("FAIL crlf_status_bit4: got %b required %b", rd[4], CRLF_BIT[4]);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (consec !== 0) begin
            errors++; $display("FAIL strobe_consecutive: got %0d required 0", consec);
        end
        checks++;
        if (badadr !== 0) begin
            errors++; $display("FAIL write_addr: got %0d bad writes required 0", badadr);
        end
        checks++;
        if (m_sel_o !== 4'hF || s_ack_o !== s_stb_i) begin
            errors++; $display("FAIL sel_ack: got sel=%h ack=%b required sel=F ack=%b", m_sel_o, s_ack_o, s_stb_i);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_busy_uart;
        test_overflow;
        test_reset_midflight;
        test_crlf;
        test_protocol;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
